serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial WIDTH-bit adder built around a single full-adder cell and a carry flip-flop. It feeds operand bits LSB-first into the cell, registers the cell's carry-out back into the cell's carry-in on every cycle, and assembles the sum bits in a shift register. It is the sequential stage wrapped around the full-adder sum/carry logic, trading WIDTH cycles of latency for one adder cell.

## Interface
- WIDTH, 8, operand and sum width in bits (≥ 2)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only in IDLE or DONE
- a  in  WIDTH  operand A, captured on accepted start
- b  in  WIDTH  operand B, captured on accepted start
- cin  in  1  carry-in, captured on accepted start
- busy  out  1  high while in SHIFT
- done  out  1  one-cycle pulse, result registers just updated
- sum  out  WIDTH  registered result, holds until next completion
- cout  out  1  registered final carry, holds until next completion

## Operation
- State machine: IDLE → SHIFT → DONE → IDLE.
- IDLE: start=1 → load a_sr=a, b_sr=b, c_q=cin, cnt=0 → SHIFT.
- SHIFT, each cycle:
  - Cell inputs are a_sr[0], b_sr[0], c_q.
  - s_sr shifts right with cell sum entering at the MSB.
  - a_sr and b_sr shift right.
  - c_q takes the cell carry; cnt increments.
  - When cnt=WIDTH-1 this cycle: sum ← the final shifted s_sr value, cout ← cell carry, → DONE.
- DONE: done=1 for exactly one cycle.
  - start=1 in DONE is accepted exactly as in IDLE (→ SHIFT); otherwise → IDLE.
- start while in SHIFT is ignored. No queueing; a, b and cin are don't-care.
- Cell function:
  - sum = a⊕b⊕c
  - carry = majority(a,b,c)
  - carry resolves to a known value whenever two inputs agree, even if the third is X.
- Result arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
- sum and cout change only on the SHIFT→DONE edge. Intermediate bits are never visible.
- cnt is $clog2(WIDTH) bits wide. Its wrap is not relied on; exit is by compare to WIDTH-1.

## Timing
- Reset (rst_n low, asynchronous, any state, including mid-SHIFT):
  - State = IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - cnt=0, c_q=0. Shift registers are cleared to 0.
  - Any operation in flight is discarded. No done pulse follows.
- Latency: start is sampled at edge E0. Bit i is processed on edge E(i+1). sum/cout update and done rises on edge E(WIDTH).
  - So done is high during the cycle following the WIDTH-th SHIFT edge, i.e. WIDTH cycles after acceptance.
- busy is high from after E0 through E(WIDTH); low in DONE and IDLE.
- Throughput: with start held high continuously, one result per WIDTH+1 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package serial_adder_pkg holds:
  - the state typedef (IDLE, SHIFT, DONE), 2-bit encoding;
  - the default WIDTH constant.
- Sub-module fa_cell: purely combinational (a, b, c → sum, carry), implementing the full-adder truth table above. It is instantiated once.
- The FSM, counter, shift registers and result registers are in serial_adder.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0 → sum=0x96, cout=0. done exactly 8 cycles after start is sampled; busy high for 8 cycles.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Also a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Start pulsed at cycle 3 of an operation with different operands → ignored; the original result is delivered, and only one done pulse occurs.
- start held high across DONE → second operation begins immediately. The previous sum/cout hold stable until the second done.
- rst_n low at cycle 4 of SHIFT → all outputs are 0 immediately (asynchronously). No done. A fresh start afterwards computes correctly.
- WIDTH=4, exhaustive: all a, b, cin (512 cases) checked against a+b+cin.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Combinational full-adder cell used by the serial adder, one bit per cycle.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum = a ^ b ^ c;
    // Sum-of-products majority: two agreeing inputs dominate an unknown third.
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, a carry flop, LSB-first shift registers.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);

    state_t           state, state_d;
    logic [WIDTH-1:0] a_sr, b_sr, s_sr, s_next;
    logic [CW-1:0]    cnt;
    logic             c_q;
    logic             cell_sum, cell_carry;
    logic             accept, last;

    fa_cell u_cell (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c     (c_q),
        .sum   (cell_sum),
        .carry (cell_carry)
    );

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
    assign s_next = {cell_sum, s_sr[WIDTH-1:1]};
    assign busy   = (state == SHIFT);
    assign done   = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (last) state_d = DONE;
            DONE:    state_d = accept ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result registers load only on the final shift so partial sums never reach the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr <= '0;
            b_sr <= '0;
            s_sr <= '0;
            c_q  <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
        end else if (accept) begin
            a_sr <= a;
            b_sr <= b;
            s_sr <= '0;
            c_q  <= cin;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            s_sr <= s_next;
            c_q  <= cell_carry;
            cnt  <= cnt + 1'b1;
            if (last) begin
                sum  <= s_next;
                cout <= cell_carry;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8 scenarios plus WIDTH=4 exhaustive sweep).
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       cin = 1'b0;
    logic       busy, done, cout;
    logic [7:0] sum;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       cin4 = 1'b0;
    logic       busy4, done4, cout4;
    logic [3:0] sum4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    // Runs one WIDTH=8 operation from IDLE; optionally pulses start with other operands at cycle inj.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input int inj,
                       output logic [7:0] rs, output logic rc, output int lat,
                       output int busy_n, output int done_n, output int early_chg);
        logic [7:0] prev_s;
        logic       prev_c;
        prev_s = sum; prev_c = cout;
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = ~ta; b = ~tb; cin = ~tc;
        lat = 0; busy_n = 0; done_n = 0; early_chg = 0; rs = 'x; rc = 1'bx;
        if (busy) busy_n++;
        for (int i = 1; i <= 20; i++) begin
            if (i == inj) begin start = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b1; end
            else start = 1'b0;
            @(posedge clk); #1;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (lat == 0) begin lat = i; rs = sum; rc = cout; end
            end else if (lat == 0 && (sum !== prev_s || cout !== prev_c)) begin
                early_chg++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({busy, done, sum, cout} !== 11'b0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b done=%b sum=%h cout=%b, required all 0", busy, done, sum, cout);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic check_op(input string name, input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                            input logic [7:0] es, input logic ec, input int inj);
        logic [7:0] rs; logic rc; int lat, bn, dn, ch;
        op8(ta, tb, tc, inj, rs, rc, lat, bn, dn, ch);
        checks++;
        if (rs !== es || rc !== ec) begin
            failures++;
            $display("FAIL %s_result: sum=%h cout=%b, required sum=%h cout=%b", name, rs, rc, es, ec);
        end
        checks++;
        if (lat !== 8) begin
            failures++;
            $display("FAIL %s_latency: done after %0d cycles, required 8", name, lat);
        end
        checks++;
        if (bn !== 8) begin
            failures++;
            $display("FAIL %s_busy: busy high %0d cycles, required 8", name, bn);
        end
        checks++;
        if (dn !== 1) begin
            failures++;
            $display("FAIL %s_done_count: %0d done pulses, required 1", name, dn);
        end
        checks++;
        if (ch !== 0) begin
            failures++;
            $display("FAIL %s_early_change: outputs moved %0d times before done, required 0", name, ch);
        end
    endtask

    task automatic test_basic();
        check_op("basic", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0);
    endtask

    task automatic test_carry();
        check_op("ff_plus_1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
        check_op("ff_ff_cin", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0);
        check_op("cin_only", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 0);
    endtask

    task automatic test_ignore_start();
        check_op("ignore_start", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 3);
    endtask

    task automatic test_back_to_back();
        int n, gap, held;
        a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        a = 8'h0F; b = 8'h01; cin = 1'b0;
        n = 0;
        while (!done && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (!done || sum !== 8'h00 || cout !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first: done=%b sum=%h cout=%b, required 1 00 1", done, sum, cout);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_restart: busy=%b, required 1", busy);
        end
        start = 1'b0;
        gap = 1; held = 1;
        while (!done && gap < 20) begin
            if (sum !== 8'h00 || cout !== 1'b1) held = 0;
            @(posedge clk); #1; gap++;
        end
        checks++;
        if (held !== 1) begin
            failures++;
            $display("FAIL b2b_hold: previous result changed before second done, held=%0d required 1", held);
        end
        checks++;
        if (gap !== 9) begin
            failures++;
            $display("FAIL b2b_throughput: done-to-done %0d cycles, required 9", gap);
        end
        checks++;
        if (sum !== 8'h10 || cout !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second: sum=%h cout=%b, required 10 0", sum, cout);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int dn;
        a = 8'h77; b = 8'h22; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, sum, cout} !== 11'b0) begin
            failures++;
            $display("FAIL midreset_async: busy=%b done=%b sum=%h cout=%b, required all 0", busy, done, sum, cout);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        dn = 0;
        repeat (12) begin @(posedge clk); #1; if (done) dn++; end
        checks++;
        if (dn !== 0 || sum !== 8'h00) begin
            failures++;
            $display("FAIL midreset_no_done: done pulses=%0d sum=%h, required 0 00", dn, sum);
        end
        check_op("after_reset", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0);
    endtask

    task automatic test_exhaustive4();
        int bad, n;
        logic [4:0] exp;
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            a4 = i[3:0]; b4 = i[7:4]; cin4 = i[8]; start4 = 1'b1;
            exp = 5'(i[3:0]) + 5'(i[7:4]) + 5'(i[8]);
            @(posedge clk); #1;
            start4 = 1'b0;
            n = 0;
            while (!done4 && n < 10) begin @(posedge clk); #1; n++; end
            checks++;
            if (!done4 || {cout4, sum4} !== exp || n !== 4) begin
                failures++;
                if (bad < 8)
                    $display("FAIL exh4 a=%h b=%h cin=%b: {cout,sum}=%h after %0d cycles, required %h after 4",
                             i[3:0], i[7:4], i[8], {cout4, sum4}, n, exp);
                bad++;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_exhaustive4();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
